// File: rtl/vlc_hybrid_codeword_if.sv
// rtl/vlc_hybrid_codeword_if.sv - symbol/codeword handshake bundle for the VLC codeword generator
//
// Purpose: groups the input symbol stream, the output codeword stream and the
// bit-count statistics of vlc_hybrid_codeword into one bundle.
// Port summary:
//   in_valid/in_ready   : input symbol handshake
//   val, mode, k_exp, k_rice, switch_bits, sign_en, sign : per-symbol fields
//   out_valid/out_ready : output codeword handshake
//   codeword, code_len, ovf : right-aligned code bits, length, overflow flag
//   clr_stats, total_bits   : statistics clear and running emitted-bit total
// Modports: master = symbol producer / codeword consumer, slave = generator.

interface vlc_hybrid_codeword_if #(
  parameter int VAL_W = 16,
  parameter int CW_W  = 48,
  parameter int LEN_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [VAL_W-1:0] val;
  logic             mode;
  logic [2:0]       k_exp;
  logic [2:0]       k_rice;
  logic [2:0]       switch_bits;
  logic             sign_en;
  logic             sign;
  logic             out_valid;
  logic             out_ready;
  logic [CW_W-1:0]  codeword;
  logic [LEN_W-1:0] code_len;
  logic             ovf;
  logic             clr_stats;
  logic [31:0]      total_bits;

  modport master (
    output in_valid, val, mode, k_exp, k_rice, switch_bits, sign_en, sign,
    output out_ready, clr_stats,
    input  in_ready, out_valid, codeword, code_len, ovf, total_bits
  );

  modport slave (
    input  in_valid, val, mode, k_exp, k_rice, switch_bits, sign_en, sign,
    input  out_ready, clr_stats,
    output in_ready, out_valid, codeword, code_len, ovf, total_bits
  );
endinterface

// File: rtl/vlc_hybrid_codeword.sv
// rtl/vlc_hybrid_codeword.sv - pipelined exp-Golomb / hybrid Rice codeword generator
//
// Purpose: turns unsigned magnitudes into exp-Golomb or hybrid Rice/exp-Golomb
// codewords (optional trailing sign bit), emitted right-aligned with their
// length, and keeps a running total of emitted bits.
// Ports:
//   clk     : clock, all state on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : vlc_hybrid_codeword_if.slave (symbol in, codeword out, stats)
// Pipeline: field capture, S1 branch select / s formation, S2 leading-one
// encode, S3 length, sign and overflow into the output registers. All ranks
// move together on adv = !out_valid | out_ready.

module vlc_hybrid_codeword #(
  parameter int VAL_W = 16,
  parameter int CW_W  = 48,
  parameter int LEN_W = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  vlc_hybrid_codeword_if.slave bus
);
  localparam int IW = VAL_W + 9;
  localparam int EW = $clog2(IW);
  localparam int PW = (CW_W > IW + 1) ? CW_W : IW + 1;
  localparam logic [IW-1:0] CW_MAX = IW'(CW_W);

  logic w_adv;
  logic w_hs;

  // Field capture rank
  logic             r0_valid;
  logic [VAL_W-1:0] r0_val;
  logic             r0_mode;
  logic [2:0]       r0_k_exp;
  logic [2:0]       r0_k_rice;
  logic [2:0]       r0_sw;
  logic             r0_sign_en;
  logic             r0_sign;

  // S1 result rank
  logic          r1_valid;
  logic          r1_rice;
  logic          r1_mode;
  logic [IW-1:0] r1_pat;
  logic [2:0]    r1_q;
  logic [2:0]    r1_k_exp;
  logic [2:0]    r1_k_rice;
  logic [2:0]    r1_sw;
  logic          r1_sign_en;
  logic          r1_sign;

  // S2 result rank
  logic          r2_valid;
  logic          r2_rice;
  logic          r2_mode;
  logic [IW-1:0] r2_pat;
  logic [2:0]    r2_q;
  logic [EW-1:0] r2_e;
  logic [2:0]    r2_k_exp;
  logic [2:0]    r2_k_rice;
  logic [2:0]    r2_sw;
  logic          r2_sign_en;
  logic          r2_sign;

  // Output rank
  logic             r3_valid;
  logic [CW_W-1:0]  r3_cw;
  logic [LEN_W-1:0] r3_len;
  logic             r3_ovf;
  logic [31:0]      r_total;

  assign w_adv        = !r3_valid || bus.out_ready;
  assign w_hs         = r3_valid && bus.out_ready;
  assign bus.in_ready = w_adv;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r0_valid   <= 1'b0;
      r0_val     <= '0;
      r0_mode    <= 1'b0;
      r0_k_exp   <= '0;
      r0_k_rice  <= '0;
      r0_sw      <= '0;
      r0_sign_en <= 1'b0;
      r0_sign    <= 1'b0;
    end else if (w_adv) begin
      r0_valid   <= bus.in_valid;
      r0_val     <= bus.val;
      r0_mode    <= bus.mode;
      r0_k_exp   <= bus.k_exp;
      r0_k_rice  <= bus.k_rice;
      r0_sw      <= bus.switch_bits;
      r0_sign_en <= bus.sign_en;
      r0_sign    <= bus.sign;
    end
  end

  // S1: branch select and pattern formation
  logic [IW-1:0] w_val_x;
  logic [IW-1:0] w_one_k;
  logic [IW-1:0] w_one_r;
  logic [IW-1:0] w_f;
  logic [IW-1:0] w_s;
  logic [IW-1:0] w_rice_pat;
  logic          w_is_rice;
  logic [2:0]    w_q;

  always_comb begin
    w_val_x    = IW'(r0_val);
    w_one_k    = IW'(1) << r0_k_exp;
    w_one_r    = IW'(1) << r0_k_rice;
    w_f        = (IW'(r0_sw) + IW'(1)) << r0_k_rice;
    w_is_rice  = r0_mode && (w_val_x < w_f);
    w_rice_pat = w_one_r | (w_val_x & (w_one_r - IW'(1)));
    // In the escape branch val >= F, so the subtraction never wraps.
    w_s        = r0_mode ? (w_val_x - w_f + w_one_k) : (w_val_x + w_one_k);
    // On the Rice branch val < (switch_bits+1) << k_rice, so the quotient
    // is at most switch_bits and three bits hold it.
    w_q        = 3'(w_val_x >> r0_k_rice);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1_valid   <= 1'b0;
      r1_rice    <= 1'b0;
      r1_mode    <= 1'b0;
      r1_pat     <= '0;
      r1_q       <= '0;
      r1_k_exp   <= '0;
      r1_k_rice  <= '0;
      r1_sw      <= '0;
      r1_sign_en <= 1'b0;
      r1_sign    <= 1'b0;
    end else if (w_adv) begin
      r1_valid   <= r0_valid;
      r1_rice    <= w_is_rice;
      r1_mode    <= r0_mode;
      r1_pat     <= w_is_rice ? w_rice_pat : w_s;
      r1_q       <= w_q;
      r1_k_exp   <= r0_k_exp;
      r1_k_rice  <= r0_k_rice;
      r1_sw      <= r0_sw;
      r1_sign_en <= r0_sign_en;
      r1_sign    <= r0_sign;
    end
  end

  // S2: position of the leading one of s (ignored on the Rice branch)
  logic [EW-1:0] w_e;

  always_comb begin
    w_e = '0;
    for (int i = 0; i < IW; i++) begin
      if (r1_pat[i]) w_e = EW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r2_valid   <= 1'b0;
      r2_rice    <= 1'b0;
      r2_mode    <= 1'b0;
      r2_pat     <= '0;
      r2_q       <= '0;
      r2_e       <= '0;
      r2_k_exp   <= '0;
      r2_k_rice  <= '0;
      r2_sw      <= '0;
      r2_sign_en <= 1'b0;
      r2_sign    <= 1'b0;
    end else if (w_adv) begin
      r2_valid   <= r1_valid;
      r2_rice    <= r1_rice;
      r2_mode    <= r1_mode;
      r2_pat     <= r1_pat;
      r2_q       <= r1_q;
      r2_e       <= w_e;
      r2_k_exp   <= r1_k_exp;
      r2_k_rice  <= r1_k_rice;
      r2_sw      <= r1_sw;
      r2_sign_en <= r1_sign_en;
      r2_sign    <= r1_sign;
    end
  end

  // S3: length, sign append and overflow check at full internal width
  logic [IW-1:0] w_len_eg;
  logic [IW-1:0] w_len_base;
  logic [IW-1:0] w_len;
  logic [IW:0]   w_pat_sg;
  logic [PW-1:0] w_pat_x;
  logic          w_ovf;

  always_comb begin
    // s >= 1 << k_exp, so e >= k_exp and this never wraps
    w_len_eg   = IW'({r2_e, 1'b0}) + IW'(1) - IW'(r2_k_exp);
    if (r2_rice) begin
      w_len_base = IW'(r2_q) + IW'(1) + IW'(r2_k_rice);
    end else if (r2_mode) begin
      w_len_base = w_len_eg + IW'(r2_sw) + IW'(1);
    end else begin
      w_len_base = w_len_eg;
    end
    w_len    = w_len_base + IW'(r2_sign_en);
    w_pat_sg = r2_sign_en ? {r2_pat, r2_sign} : {1'b0, r2_pat};
    w_pat_x  = PW'(w_pat_sg);
    w_ovf    = w_len > CW_MAX;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r3_valid <= 1'b0;
      r3_cw    <= '0;
      r3_len   <= '0;
      r3_ovf   <= 1'b0;
    end else if (w_adv) begin
      r3_valid <= r2_valid;
      r3_ovf   <= r2_valid && w_ovf;
      if (r2_valid && !w_ovf) begin
        r3_cw  <= w_pat_x[CW_W-1:0];
        r3_len <= LEN_W'(w_len);
      end else begin
        r3_cw  <= '0;
        r3_len <= '0;
      end
    end
  end

  // Clear wins over accumulation but still counts a coincident handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_total <= '0;
    end else if (bus.clr_stats) begin
      r_total <= w_hs ? 32'(r3_len) : 32'd0;
    end else if (w_hs) begin
      r_total <= r_total + 32'(r3_len);
    end
  end

  assign bus.out_valid  = r3_valid;
  assign bus.codeword   = r3_cw;
  assign bus.code_len   = r3_len;
  assign bus.ovf        = r3_ovf;
  assign bus.total_bits = r_total;

endmodule

// File: tb/tb_vlc_hybrid_codeword.sv
// tb/tb_vlc_hybrid_codeword.sv - self-checking bench for vlc_hybrid_codeword

module tb_vlc_hybrid_codeword;
  localparam int VAL_W = 16;
  localparam int CW_W  = 16;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vlc_hybrid_codeword_if #(.VAL_W(VAL_W), .CW_W(CW_W), .LEN_W(LEN_W)) bus ();

  vlc_hybrid_codeword #(.VAL_W(VAL_W), .CW_W(CW_W), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [63:0] cw;
    int          len;
    bit          ovf;
  } exp_t;

  exp_t        expq[$];
  int          seen_len[$];
  logic [31:0] m_total = 32'd0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Reference: codeword straight from the coding rules with plain arithmetic.
  function automatic exp_t model(input logic [15:0] v, input logic md,
                                 input logic [2:0] ke3, input logic [2:0] kr3,
                                 input logic [2:0] sw3, input logic se, input logic sg);
    exp_t   r;
    longint s, pat, f, lv;
    int     ke, kr, sw, e, len;
    ke = int'(ke3);
    kr = int'(kr3);
    sw = int'(sw3);
    lv = longint'(v);
    if (!md) begin
      s   = lv + (longint'(1) << ke);
      e   = $clog2(s + 1) - 1;
      len = 2 * e - ke + 1;
      pat = s;
    end else begin
      f = longint'(sw + 1) << kr;
      if (lv < f) begin
        len = int'(lv >> kr) + 1 + kr;
        pat = (longint'(1) << kr) + (lv % (longint'(1) << kr));
      end else begin
        s   = lv - f + (longint'(1) << ke);
        e   = $clog2(s + 1) - 1;
        len = 2 * e - ke + sw + 2;
        pat = s;
      end
    end
    if (se) begin
      pat = pat * 2 + longint'(sg);
      len = len + 1;
    end
    if (len > CW_W) begin
      r.ovf = 1'b1;
      r.cw  = 64'd0;
      r.len = 0;
    end else begin
      r.ovf = 1'b0;
      r.cw  = 64'(pat);
      r.len = len;
    end
    return r;
  endfunction

  // Scoreboard: sampled on the falling edge, ahead of the edge that commits.
  always @(negedge clk) begin
    exp_t e;
    int   elen;
    if (!reset_n) begin
      expq.delete();
      m_total = 32'd0;
    end else begin
      chk("total_bits", 64'(bus.total_bits), 64'(m_total));
      elen = 0;
      if (bus.out_valid && bus.out_ready) begin
        seen_len.push_back(int'(bus.code_len));
        if (expq.size() == 0) begin
          chk("spurious_output", 64'd1, 64'd0);
        end else begin
          e = expq.pop_front();
          chk("codeword", 64'(bus.codeword), e.cw);
          chk("code_len", 64'(bus.code_len), 64'(e.len));
          chk("ovf", 64'(bus.ovf), 64'(e.ovf));
          elen = e.len;
        end
      end
      if (bus.in_valid && bus.in_ready)
        expq.push_back(model(bus.val, bus.mode, bus.k_exp, bus.k_rice,
                             bus.switch_bits, bus.sign_en, bus.sign));
      m_total = bus.clr_stats ? 32'(elen) : m_total + 32'(elen);
    end
  end

  task automatic drive(input logic [15:0] v, input logic md, input logic [2:0] ke,
                       input logic [2:0] kr, input logic [2:0] sw,
                       input logic se, input logic sg);
    bit ok = 1'b0;
    bus.val = v;
    bus.mode = md;
    bus.k_exp = ke;
    bus.k_rice = kr;
    bus.switch_bits = sw;
    bus.sign_en = se;
    bus.sign = sg;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_directed(input logic [15:0] v, input logic md, input logic [2:0] ke,
                              input logic [2:0] kr, input logic [2:0] sw,
                              input logic se, input logic sg,
                              input logic [63:0] want_cw, input int want_len,
                              input logic want_ovf);
    int lat = 0;
    drive(v, md, ke, kr, sw, se, sg);
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd3);
    chk("dir_codeword", 64'(bus.codeword), want_cw);
    chk("dir_code_len", 64'(bus.code_len), 64'(want_len));
    chk("dir_ovf", 64'(bus.ovf), 64'(want_ovf));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || bus.out_valid) && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 500) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_clr();
    bus.clr_stats = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_stats = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bp_lens[6] = '{1, 3, 3, 5, 5, 5};
    bus.in_valid = 1'b0;
    bus.val = '0;
    bus.mode = 1'b0;
    bus.k_exp = '0;
    bus.k_rice = '0;
    bus.switch_bits = '0;
    bus.sign_en = 1'b0;
    bus.sign = 1'b0;
    bus.out_ready = 1'b1;
    bus.clr_stats = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_codeword", 64'(bus.codeword), 64'd0);
    chk("rst_code_len", 64'(bus.code_len), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    chk("rst_total", 64'(bus.total_bits), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Exp-Golomb, hybrid Rice/escape and sign examples
    run_directed(16'd0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 64'h1, 1, 1'b0);
    run_directed(16'd3, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 64'h4, 5, 1'b0);
    run_directed(16'd5, 1'b0, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0, 64'h9, 5, 1'b0);
    run_directed(16'd3, 1'b1, 3'd2, 3'd1, 3'd1, 1'b0, 1'b0, 64'h3, 3, 1'b0);
    run_directed(16'd4, 1'b1, 3'd2, 3'd1, 3'd1, 1'b0, 1'b0, 64'h4, 5, 1'b0);
    run_directed(16'd3, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 64'h9, 6, 1'b0);
    run_directed(16'd3, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 64'h8, 6, 1'b0);

    // Overflow: length 33 exceeds CW_W = 16
    pulse_clr();
    chk("clr_total", 64'(bus.total_bits), 64'd0);
    run_directed(16'hFFFF, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 64'h0, 0, 1'b1);
    chk("ovf_total", 64'(bus.total_bits), 64'd0);

    // Back-pressure
    seen_len.delete();
    fork
      begin
        for (int i = 0; i < 6; i++)
          drive(16'(i), 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(seen_len.size()), 64'd6);
    for (int i = 0; i < 6 && i < seen_len.size(); i++)
      chk("bp_len_order", 64'(seen_len[i]), 64'(bp_lens[i]));
    chk("bp_total", 64'(bus.total_bits), 64'd22);

    // Reset with two symbols in flight
    drive(16'd10, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    drive(16'd20, 1'b0, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_total", 64'(bus.total_bits), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_directed(16'd5, 1'b0, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0, 64'h9, 5, 1'b0);

    // Clear coincident with a length-5 handshake
    drive(16'd5, 1'b0, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !bus.out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    bus.clr_stats = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_stats = 1'b0;
    chk("clr_hs_total", 64'(bus.total_bits), 64'd5);

    // Randomized traffic with random back-pressure and clears
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          int gap;
          logic [15:0] v;
          gap = ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0;
          repeat (gap) begin
            @(posedge clk);
            #1;
          end
          v = ($urandom % 2 == 0) ? 16'($urandom_range(0, 63)) : 16'($urandom);
          drive(v, 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                1'($urandom), 1'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom % 4) != 0;
          bus.clr_stats = ($urandom % 20) == 0;
        end
        bus.out_ready = 1'b1;
        bus.clr_stats = 1'b0;
      end
    join
    drain();
    chk("final_queue_empty", 64'(expq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vlc_hybrid_codeword.md
# vlc_hybrid_codeword

Parametrised, pipelined variable-length-code generator for the ProRes VLC path. It produces exp-Golomb codewords, or ProRes hybrid Rice/exp-Golomb codewords, with an optional appended sign bit. Each codeword is emitted as a right-aligned bit pattern plus its length. It sits between the coefficient scan/quantiser and the bit packer, uses a valid/ready handshake on both sides, and keeps a running emitted-bit total for rate control.

## Interface
Parameters:
- VAL_W, 16: magnitude input width.
- CW_W, 48: codeword output width; also the maximum legal length.
- LEN_W, 8: code_len width; must satisfy 2^LEN_W > CW_W.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input symbol present.
- in_ready  out  1  block accepts the symbol this cycle.
- val  in  VAL_W  unsigned magnitude.
- mode  in  1  0 = pure exp-Golomb, 1 = hybrid Rice/exp-Golomb.
- k_exp  in  3  exp-Golomb order.
- k_rice  in  3  Rice order; used in mode 1 only.
- switch_bits  in  3  Rice-to-exp switch threshold; used in mode 1 only.
- sign_en  in  1  append a sign bit.
- sign  in  1  sign bit value; 1 = negative.
- out_valid  out  1  codeword present.
- out_ready  in  1  downstream accepts the codeword.
- codeword  out  CW_W  code bits, right-aligned; MSB of the code is at bit code_len-1; bits above code_len are 0.
- code_len  out  LEN_W  codeword length in bits.
- ovf  out  1  the computed length exceeded CW_W.
- clr_stats  in  1  synchronous clear of total_bits.
- total_bits  out  32  running sum of code_len over output handshakes.

## Operation
- All arithmetic uses VAL_W+9 internal bits. There is no truncation before the length check.

Mode 0 (exp-Golomb):
- s = val + (1<<k_exp); e = floor(log2 s).
- len = 2e - k_exp + 1; pattern = s.

Mode 1 (hybrid):
- F = (switch_bits+1) << k_rice; q = val >> k_rice.
- If val < F (Rice branch):
  - len = q + 1 + k_rice.
  - pattern = (1<<k_rice) | (val & ((1<<k_rice)-1)).
- Otherwise (escape branch):
  - s = val - F + (1<<k_exp); e = floor(log2 s).
  - len = 2e - k_exp + switch_bits + 2; pattern = s.
  - The code is (e - k_exp + switch_bits + 1) zeros followed by the e+1 bits of s.

Sign and overflow:
- sign_en = 1: codeword = (pattern<<1) | sign and len += 1.
- If final len > CW_W: ovf = 1, codeword = 0, code_len = 0. The symbol is still emitted and handshaken.

Pipeline (3 stages):
- S1: register the fields; select the branch; form s or the Rice pattern.
- S2: leading-one priority encode of s to get e.
- S3: compute len; apply sign and overflow; drive the outputs.

Flow control and statistics:
- Global advance: adv = !out_valid | out_ready.
- in_ready = adv. All stages shift together when adv = 1 and hold when adv = 0.
- Empty stages carry valid = 0 (bubbles). Bubbles are not collapsed.
- total_bits += code_len on each out_valid & out_ready. It wraps modulo 2^32.
- clr_stats has priority: total_bits = 0, or = code_len if a handshake occurs in the same cycle.

## Timing
- Reset values: in_ready = 1 once reset deasserts; out_valid = 0, codeword = 0, code_len = 0, ovf = 0, total_bits = 0. All internal stage valids are 0.
- Latency: a symbol accepted at edge N appears with out_valid = 1 after edge N+3 if no stall occurs.
- Throughput is 1 symbol per clock with out_ready held high.
- Output fields stay stable while out_valid & !out_ready.
- in_ready falls combinationally in the same cycle that out_valid & !out_ready.
- Symbols are never dropped, duplicated, or reordered.
- Reset asserted mid-stream discards all in-flight symbols immediately, with no partial output.
- Per-symbol config (mode, orders, switch_bits, sign_en) is captured with val at acceptance. Config changes between symbols take effect with no gap.

## Test plan
- Mode 0, k_exp=0, val=0 / val=3; then k_exp=2, val=5 -> codewords 0x1 len 1 / 0x4 len 5 / 0x9 len 5; each appears 3 cycles after acceptance.
- Mode 1, k_rice=1, k_exp=2, switch_bits=1; val=3 then val=4 -> 0x3 len 3 (Rice) / 0x4 len 5 (escape, "00100").
- Mode 0, k_exp=0, val=3, sign_en=1, sign=1 -> codeword 0x9 len 6; with sign=0 -> 0x8 len 6.
- Overflow: CW_W=16, mode 0, k_exp=0, val=0xFFFF -> ovf=1, codeword 0, code_len 0, handshake still completes; total_bits unchanged.
- Back-pressure: stream 6 mode-0 symbols (val 0..5, k_exp 0); hold out_ready low for cycles 4..8 -> in_ready low while stalled. Outputs appear in order: lengths 1, 3, 3, 5, 5, 5. total_bits = 22 after the last handshake.
- Pulse reset_n low with 2 symbols in flight -> out_valid 0 and total_bits 0 immediately. The next accepted symbol emerges 3 cycles after acceptance. clr_stats coincident with a len-5 handshake -> total_bits = 5.
